dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255; bus-wait cycles before abort, range 1..255.
REQ-002 Parameter AW, default 32; bus address width.
REQ-003 Single clock, reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 cmd_inM  in  2  M-stage command: 2'b11 load, 2'b10 store, 2'b01 jump, 2'b00 other.
REQ-007 flashM  in  1  M-stage flush from hazard unit.
REQ-008 addrM  in  AW  effective address.
REQ-009 wdataM  in  32  store data, right-aligned.
REQ-010 sizeM  in  2  access size: 00 byte, 01 half, 10 word; 11 is illegal.
REQ-011 unsM  in  1  load zero-extend when 1, sign-extend when 0.
REQ-012 bus_req  out  1  request, held until bus_ack.
REQ-013 bus_we  out  1  write strobe.
REQ-014 bus_addr  out  AW  word-aligned address, bits [1:0] = 0.
REQ-015 bus_wdata  out  32  lane-replicated store data.
REQ-016 bus_be  out  4  byte enables.
REQ-017 bus_ack  in  1  transfer complete, one cycle.
REQ-018 bus_rdata  in  32  read data, valid with bus_ack.
REQ-019 stall_out  out  1  to hazard unit stall_in; freezes pipeline.
REQ-020 ack_out  out  1  to hazard unit ack_in; one-cycle access-complete pulse.
REQ-021 rdata_out  out  32  extended load data, valid while ack_out is 1.
REQ-022 err_out  out  1  misalign or timeout, valid while ack_out is 1.

Function
REQ-023 FSM states: IDLE, REQ, DONE.
- IDLE -> REQ: load or store, flashM = 0, aligned access.
- IDLE -> DONE: load or store, flashM = 0, misaligned access.
- REQ -> DONE: bus_ack, or timeout.
- DONE -> IDLE: unconditional.
REQ-024 Alignment rules: half is misaligned when addr[0] = 1; word is misaligned when addr[1:0] != 0; size 11 is always misaligned.
- A misaligned access issues no bus request.
- It sets err_out = 1 and rdata_out = 0 in DONE.
REQ-025 Entering REQ latches address, we, be, wdata, size and uns into registers.
- Bus outputs are driven only from these registers.
REQ-026 Byte enables:
- byte: be = 1 << addr[1:0]
- half: be = 2'b11 << addr[1:0]
- word: be = 4'hF
REQ-027 Store data lanes: bus_wdata = {4{wdata[7:0]}} for byte, {2{wdata[15:0]}} for half, wdata for word.
REQ-028 Load data: the selected lane is shifted to bit 0, then sign- or zero-extended per uns.
- It is registered on bus_ack and presented in DONE.
REQ-029 stall_out = (IDLE and load/store and not flashM) or REQ; it is 0 in DONE.
REQ-030 Latency: minimum 2 cycles (REQ with same-cycle ack, then DONE).
- stall_out is high for exactly the number of REQ cycles plus the issue cycle.
REQ-031 bus_req is 1 in REQ only; it is deasserted the cycle after bus_ack.
REQ-032 Wait counter: 8-bit, cleared on REQ entry, incremented every REQ cycle without ack.
- When count reaches TIMEOUT-1 without ack: drop bus_req, go to DONE, err_out = 1, rdata_out = 0.
- bus_ack in that same cycle wins and gives a normal completion.
REQ-033 ack_out = 1 in DONE only, except when the kill flag is set.
REQ-034 flashM while in REQ sets the kill flag.
- The bus transfer still completes.
- DONE then asserts neither ack_out nor err_out.
- The flag clears on IDLE entry.
REQ-035 The DONE cycle never re-issues, even if cmd_inM still shows the same load/store.
- Back-to-back accesses leave IDLE on the cycle after DONE.
REQ-036 Jump and other commands in IDLE: no state change, stall_out = 0.

Reset
REQ-037 Reset takes priority over all inputs.
- The FSM enters IDLE mid-transfer; no completion is reported.
REQ-038 Reset values: every output 0, counter 0, kill flag 0, latched registers 0.

Structure
REQ-039 A shared cpu package holds:
- command encodings (lw_cmd, st_cmd, jmp_cmd, other)
- size encodings
- FSM state encodings
REQ-040 One sub-module, dmem_align: combinational be/wdata lane generation, misalign detection, and load extraction/extension.

Verification
REQ-041 Word load 0x100, ack after 3 wait cycles, rdata 0xDEADBEEF:
- bus_req held 4 cycles, stall_out held 5 cycles.
- Then ack_out = 1 with rdata_out = 0xDEADBEEF.
REQ-042 Byte store 0xA5 to addr 0x203:
- bus_addr = 0x200, bus_be = 4'b1000, bus_wdata = 0xA5A5A5A5, bus_we = 1.
REQ-043 Signed half load at addr 0x2, rdata 0x80010000 gives 0xFFFF8001; the unsigned load gives 0x00008001.
REQ-044 Word load at 0x101:
- No bus_req; stall_out for 1 cycle.
- ack_out = 1, err_out = 1, rdata_out = 0.
REQ-045 TIMEOUT = 4 with no ack:
- bus_req for 4 cycles, then ack_out = 1 with err_out = 1.
- A later load completes normally.
REQ-046 Corner cases:
- flashM in the 2nd REQ cycle, then ack: no ack_out.
- reset in mid-REQ: bus_req = 0 on the next cycle, FSM in IDLE.

Source files
------------

// File: rtl/dmem_ctrl_pkg.sv
// Shared encodings for the data-memory controller: M-stage commands,
// access sizes and controller FSM states.
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    OTHER_CMD = 2'b00,
    JMP_CMD   = 2'b01,
    ST_CMD    = 2'b10,
    LW_CMD    = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/dmem_align.sv
// Byte-lane logic: store enables/replication, misalign detection, and
// load lane extraction with sign/zero extension.
module dmem_align
  import dmem_ctrl_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  size_e       size,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lanes,
  output logic        misalign,
  input  logic [1:0]  ld_addr_lo,
  input  size_e       ld_size,
  input  logic        ld_uns,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    be          = '0;
    wdata_lanes = wdata;
    misalign    = 1'b0;
    case (size)
      SZ_BYTE: begin
        be          = 4'b0001 << addr_lo;
        wdata_lanes = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        be          = 4'b0011 << addr_lo;
        wdata_lanes = {2{wdata[15:0]}};
        misalign    = addr_lo[0];
      end
      SZ_WORD: begin
        be       = 4'hF;
        misalign = |addr_lo;
      end
      default: misalign = 1'b1;
    endcase
  end

  always_comb begin
    byte_sel = rdata[7:0];
    case (ld_addr_lo)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (ld_size)
      SZ_BYTE: ld_data = {{24{~ld_uns & byte_sel[7]}}, byte_sel};
      SZ_HALF: ld_data = {{16{~ld_uns & half_sel[15]}}, half_sel};
      SZ_WORD: ld_data = rdata;
      default: ld_data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// M-stage data-memory controller: issues one bus transfer per load/store,
// stalls the pipeline meanwhile, and reports completion/error to the hazard unit.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned AW      = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    cmd_inM,
  input  logic          flashM,
  input  logic [AW-1:0] addrM,
  input  logic [31:0]   wdataM,
  input  logic [1:0]    sizeM,
  input  logic          unsM,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [31:0]   bus_wdata,
  output logic [3:0]    bus_be,
  input  logic          bus_ack,
  input  logic [31:0]   bus_rdata,
  output logic          stall_out,
  output logic          ack_out,
  output logic [31:0]   rdata_out,
  output logic          err_out
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_e        state_q;
  logic [AW-1:0] addr_q;
  logic [1:0]    lo_q;
  logic          we_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;
  size_e         size_q;
  logic          uns_q;
  logic [7:0]    cnt_q;
  logic          kill_q;
  logic          ack_q;
  logic          err_q;
  logic [31:0]   rdata_q;

  cmd_e          cmd;
  logic          issue;
  logic          kill_next;
  logic [3:0]    be_c;
  logic [31:0]   lanes_c;
  logic          misalign_c;
  logic [31:0]   ld_data_c;

  assign cmd       = cmd_e'(cmd_inM);
  assign issue     = (state_q == ST_IDLE) && ((cmd == LW_CMD) || (cmd == ST_CMD)) && !flashM;
  assign kill_next = kill_q | flashM;

  dmem_align u_align (
    .addr_lo     (addrM[1:0]),
    .size        (size_e'(sizeM)),
    .wdata       (wdataM),
    .be          (be_c),
    .wdata_lanes (lanes_c),
    .misalign    (misalign_c),
    .ld_addr_lo  (lo_q),
    .ld_size     (size_q),
    .ld_uns      (uns_q),
    .rdata       (bus_rdata),
    .ld_data     (ld_data_c)
  );

  assign stall_out = issue || (state_q == ST_REQ);
  assign bus_req   = (state_q == ST_REQ);
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_be    = be_q;
  assign ack_out   = ack_q;
  assign err_out   = err_q;
  assign rdata_out = rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      lo_q    <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      cnt_q   <= '0;
      kill_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (issue) begin
            if (misalign_c) begin
              state_q <= ST_DONE;
              ack_q   <= 1'b1;
              err_q   <= 1'b1;
              rdata_q <= '0;
            end else begin
              state_q <= ST_REQ;
              addr_q  <= {addrM[AW-1:2], 2'b00};
              lo_q    <= addrM[1:0];
              we_q    <= (cmd == ST_CMD);
              be_q    <= be_c;
              wdata_q <= lanes_c;
              size_q  <= size_e'(sizeM);
              uns_q   <= unsM;
              cnt_q   <= '0;
            end
          end
        end
        ST_REQ: begin
          kill_q <= kill_next;
          // A same-cycle ack takes priority over the timeout abort.
          if (bus_ack) begin
            state_q <= ST_DONE;
            ack_q   <= !kill_next;
            err_q   <= 1'b0;
            rdata_q <= (kill_next || we_q) ? '0 : ld_data_c;
          end else if (cnt_q == WAIT_LAST) begin
            state_q <= ST_DONE;
            ack_q   <= !kill_next;
            err_q   <= !kill_next;
            rdata_q <= '0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          kill_q  <= 1'b0;
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          rdata_q <= '0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl (TIMEOUT = 4): loads, stores, misalign,
// timeout, flush-kill and mid-transfer reset.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  cmd_inM;
  logic        flashM;
  logic [31:0] addrM;
  logic [31:0] wdataM;
  logic [1:0]  sizeM;
  logic        unsM;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        stall_out;
  logic        ack_out;
  logic [31:0] rdata_out;
  logic        err_out;

  int unsigned nerr = 0;
  int unsigned nchk = 0;

  int unsigned r_req, r_stall;
  logic        r_done, r_ack, r_err, r_we;
  logic [31:0] r_rdata, r_addr, r_wdata;
  logic [3:0]  r_be;

  always #5 clk = ~clk;

  dmem_ctrl #(.TIMEOUT(4), .AW(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_inM   (cmd_inM),
    .flashM    (flashM),
    .addrM     (addrM),
    .wdataM    (wdataM),
    .sizeM     (sizeM),
    .unsM      (unsM),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_be    (bus_be),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata),
    .stall_out (stall_out),
    .ack_out   (ack_out),
    .rdata_out (rdata_out),
    .err_out   (err_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Runs one access; acks on REQ cycle wait_n+1 and flushes on REQ cycle flush_at.
  task automatic xfer(input logic [1:0] c, input logic [31:0] a, input logic [31:0] wd,
                      input logic [1:0] sz, input logic u, input int unsigned wait_n,
                      input int unsigned flush_at, input logic [31:0] rd);
    logic seen;
    seen = 1'b0;
    r_req = 0; r_stall = 0; r_done = 1'b0;
    r_ack = 1'b0; r_err = 1'b0; r_rdata = '0;
    r_addr = '0; r_wdata = '0; r_be = '0; r_we = 1'b0;
    cmd_inM = c; addrM = a; wdataM = wd; sizeM = sz; unsM = u;
    bus_rdata = rd;
    for (int cyc = 0; cyc < 40 && !r_done; cyc++) begin
      if (bus_req) begin
        r_req++;
        if (r_req == 1) begin
          r_addr = bus_addr; r_be = bus_be; r_wdata = bus_wdata; r_we = bus_we;
        end
      end
      bus_ack = bus_req && (r_req == wait_n + 1);
      flashM  = bus_req && (r_req == flush_at);
      #2;
      if (stall_out) begin
        r_stall++;
        seen = 1'b1;
      end else if (seen) begin
        r_done = 1'b1;
        r_ack = ack_out; r_err = err_out; r_rdata = rdata_out;
        cmd_inM = 2'b00;
      end
      adv();
    end
    bus_ack = 1'b0;
    flashM  = 1'b0;
    chk("xfer_finished", {31'd0, r_done}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cmd_inM = 2'b00; flashM = 1'b0; addrM = '0; wdataM = '0;
    sizeM = 2'b00; unsM = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
    adv(); adv();
    reset = 1'b0;
    #2;
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_stall", {31'd0, stall_out}, 32'd0);
    chk("rst_ack", {31'd0, ack_out}, 32'd0);
    chk("rst_err", {31'd0, err_out}, 32'd0);
    chk("rst_rdata", rdata_out, 32'h0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_be", {28'd0, bus_be}, 32'h0);
    chk("rst_bus_we", {31'd0, bus_we}, 32'd0);
    adv();

    // Word load, 3 wait cycles; the ack lands on the timeout boundary and wins.
    xfer(2'b11, 32'h100, 32'h0, 2'b10, 1'b0, 3, 0, 32'hDEADBEEF);
    chk("lw_req_cycles", r_req, 32'd4);
    chk("lw_stall_cycles", r_stall, 32'd5);
    chk("lw_bus_addr", r_addr, 32'h100);
    chk("lw_bus_be", {28'd0, r_be}, 32'hF);
    chk("lw_bus_we", {31'd0, r_we}, 32'd0);
    chk("lw_ack", {31'd0, r_ack}, 32'd1);
    chk("lw_err", {31'd0, r_err}, 32'd0);
    chk("lw_rdata", r_rdata, 32'hDEADBEEF);
    chk("lw_idle_req", {31'd0, bus_req}, 32'd0);

    xfer(2'b10, 32'h203, 32'h123456A5, 2'b00, 1'b0, 0, 0, 32'h0);
    chk("sb_bus_addr", r_addr, 32'h200);
    chk("sb_bus_be", {28'd0, r_be}, 32'h8);
    chk("sb_bus_wdata", r_wdata, 32'hA5A5A5A5);
    chk("sb_bus_we", {31'd0, r_we}, 32'd1);
    chk("sb_req_cycles", r_req, 32'd1);
    chk("sb_stall_cycles", r_stall, 32'd2);
    chk("sb_ack", {31'd0, r_ack}, 32'd1);

    xfer(2'b11, 32'h2, 32'h0, 2'b01, 1'b0, 1, 0, 32'h80010000);
    chk("lh_bus_be", {28'd0, r_be}, 32'hC);
    chk("lh_rdata", r_rdata, 32'hFFFF8001);
    chk("lh_stall_cycles", r_stall, 32'd3);
    xfer(2'b11, 32'h2, 32'h0, 2'b01, 1'b1, 0, 0, 32'h80010000);
    chk("lhu_rdata", r_rdata, 32'h00008001);

    xfer(2'b11, 32'h101, 32'h0, 2'b10, 1'b0, 0, 0, 32'h12345678);
    chk("mis_req_cycles", r_req, 32'd0);
    chk("mis_stall_cycles", r_stall, 32'd1);
    chk("mis_ack", {31'd0, r_ack}, 32'd1);
    chk("mis_err", {31'd0, r_err}, 32'd1);
    chk("mis_rdata", r_rdata, 32'h0);

    xfer(2'b11, 32'h40, 32'h0, 2'b11, 1'b0, 0, 0, 32'h12345678);
    chk("ill_req_cycles", r_req, 32'd0);
    chk("ill_err", {31'd0, r_err}, 32'd1);

    xfer(2'b11, 32'h80, 32'h0, 2'b10, 1'b0, 100, 0, 32'hCAFEF00D);
    chk("to_req_cycles", r_req, 32'd4);
    chk("to_stall_cycles", r_stall, 32'd5);
    chk("to_ack", {31'd0, r_ack}, 32'd1);
    chk("to_err", {31'd0, r_err}, 32'd1);
    chk("to_rdata", r_rdata, 32'h0);

    // Flush in the 2nd REQ cycle: the bus transfer finishes but is not reported.
    xfer(2'b11, 32'h300, 32'h0, 2'b10, 1'b0, 2, 2, 32'h11112222);
    chk("kill_req_cycles", r_req, 32'd3);
    chk("kill_ack", {31'd0, r_ack}, 32'd0);
    chk("kill_err", {31'd0, r_err}, 32'd0);

    xfer(2'b11, 32'h7, 32'h0, 2'b00, 1'b0, 2, 0, 32'h8F000000);
    chk("lb_after_kill_ack", {31'd0, r_ack}, 32'd1);
    chk("lb_rdata", r_rdata, 32'hFFFFFF8F);
    chk("lb_err", {31'd0, r_err}, 32'd0);
    xfer(2'b11, 32'h1, 32'h0, 2'b00, 1'b1, 0, 0, 32'h12345678);
    chk("lbu_rdata", r_rdata, 32'h00000056);

    xfer(2'b10, 32'h12, 32'hFFFFBEEF, 2'b01, 1'b0, 0, 0, 32'h0);
    chk("sh_bus_be", {28'd0, r_be}, 32'hC);
    chk("sh_bus_wdata", r_wdata, 32'hBEEFBEEF);
    chk("sh_bus_addr", r_addr, 32'h10);

    cmd_inM = 2'b01; addrM = 32'h100; sizeM = 2'b10;
    #2;
    chk("jmp_stall", {31'd0, stall_out}, 32'd0);
    adv();
    chk("jmp_bus_req", {31'd0, bus_req}, 32'd0);
    cmd_inM = 2'b11; flashM = 1'b1;
    #2;
    chk("flush_idle_stall", {31'd0, stall_out}, 32'd0);
    adv();
    chk("flush_idle_req", {31'd0, bus_req}, 32'd0);
    flashM = 1'b0;
    #2;
    chk("issue_stall", {31'd0, stall_out}, 32'd1);
    adv();
    chk("midreq_bus_req", {31'd0, bus_req}, 32'd1);
    reset = 1'b1; cmd_inM = 2'b00; bus_ack = 1'b1; bus_rdata = 32'h55555555;
    adv();
    chk("rstreq_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rstreq_ack", {31'd0, ack_out}, 32'd0);
    reset = 1'b0; bus_ack = 1'b0;
    #2;
    chk("rstreq_stall", {31'd0, stall_out}, 32'd0);
    adv();
    chk("rstreq_idle_req", {31'd0, bus_req}, 32'd0);
    chk("rstreq_idle_ack", {31'd0, ack_out}, 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
